// File: rtl/softmax_div_out_pkg.sv
// Shared definitions for the softmax output divide stage: FSM encoding, FP constants,
// and the single-precision divide used as the divider core behind a fixed-latency pipe.
package softmax_div_out_pkg;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned AW      = 6;
  localparam int unsigned DIV_LAT = 6;
  localparam int unsigned LW      = AW + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FILL     = 3'd1;
  localparam logic [2:0] ST_WAIT_SUM = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_FLUSH    = 3'd4;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_EXP_MASK = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  // IEEE-754 single divide, round-to-nearest-even; denormals flushed to zero.
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic [48:0]       num, den, q, r;
    logic [25:0]       qs;
    logic [23:0]       m;
    logic              g, s, inc;
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic [31:0]       res;
    sgn = a[31] ^ b[31];
    ea  = a[30:23];
    fa  = a[22:0];
    eb  = b[30:23];
    fb  = b[22:0];
    res = {sgn, 31'd0};
    if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0) ||
        (ea == 8'hFF && eb == 8'hFF) || (ea == 8'h00 && eb == 8'h00)) begin
      res = FP_QNAN;
    end else if (ea == 8'hFF || eb == 8'h00) begin
      res = {sgn, 8'hFF, 23'd0};
    end else if (eb == 8'hFF || ea == 8'h00) begin
      res = {sgn, 31'd0};
    end else begin
      num = {1'b1, fa, 25'd0};
      den = {25'd0, 1'b1, fb};
      q   = num / den;
      r   = num % den;
      qs  = 26'(q);
      e   = 10'(ea) - 10'(eb) + 10'd127;
      if (qs[25]) begin
        m = qs[25:2];
        g = qs[1];
        s = qs[0] | (r != 49'd0);
      end else begin
        m = qs[24:1];
        g = qs[0];
        s = (r != 49'd0);
        e = e - 10'sd1;
      end
      inc = g & (s | m[0]);
      mr  = {1'b0, m} + 25'(inc);
      if (mr[24]) begin
        mr = mr >> 1;
        e  = e + 10'sd1;
      end
      if (e >= 10'sd255) begin
        res = {sgn, 8'hFF, 23'd0};
      end else if (e <= 10'sd0) begin
        res = {sgn, 31'd0};
      end else begin
        res = {sgn, 8'(e), 23'(mr)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/softmax_div_out_buf.sv
// Simple dual-port element buffer with one-cycle synchronous read.
module softmax_div_buf
  import softmax_div_out_pkg::*;
#(
  parameter int unsigned W = DW,
  parameter int unsigned N = DEPTH,
  parameter int unsigned A = AW
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/softmax_div_out.sv
// Buffers one vector of exponentials, then streams exp/sum through a fixed-latency divider.
// SOFTMAX_DIV_ZERO_GUARD_EN: a zero/denormal sum forces every result to +0.0.
module softmax_div_out
  import softmax_div_out_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] exp_in,
  input  logic          exp_valid,
  input  logic          exp_last,
  output logic          in_ready,
  input  logic [DW-1:0] sum_in,
  input  logic          sum_valid,
  output logic [DW-1:0] prob_out,
  output logic          prob_valid,
  output logic          prob_last,
  output logic          busy,
  output logic          ovf_err
);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic [DW-1:0]    sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [DIV_LAT:0] vld_q, vld_d;
  logic [DIV_LAT:0] lst_q, lst_d;
  logic [DW-1:0]    dat_q [DIV_LAT];
  logic [DW-1:0]    dat_d [DIV_LAT];

  logic             accept_c, wr_en_c, rd_en_c, last_issue_c;
  logic [DW-1:0]    rd_data, div_c;

  softmax_div_buf #(.W(DW), .N(DEPTH), .A(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_cnt_q),
    .wr_data (exp_in),
    .rd_en   (rd_en_c),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data)
  );

  // Vector control FSM; wr_cnt is returned to zero on leaving the fill phase.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    len_d        = len_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    last_issue_c = 1'b0;
    accept_c     = exp_valid && in_ready_q;
    case (state_q)
      ST_IDLE: begin
        wr_cnt_d = '0;
        if (accept_c) begin
          wr_en_c = 1'b1;
          if (exp_last) begin
            len_d   = LW'(1);
            state_d = ST_WAIT_SUM;
          end else begin
            wr_cnt_d = AW'(1);
            state_d  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (accept_c) begin
          wr_en_c  = 1'b1;
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (exp_last || wr_cnt_q == AW'(DEPTH - 1)) begin
            len_d    = LW'(wr_cnt_q) + LW'(1);
            wr_cnt_d = '0;
            state_d  = ST_WAIT_SUM;
            if (!exp_last) ovf_d = 1'b1;
          end
        end
      end
      ST_WAIT_SUM: begin
        if (sum_valid) begin
          sum_d    = sum_in;
          rd_cnt_d = '0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd_en_c  = 1'b1;
        rd_cnt_d = rd_cnt_q + AW'(1);
        if (LW'(rd_cnt_q) + LW'(1) == len_q) begin
          last_issue_c = 1'b1;
          state_d      = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave once only the output stage can still hold a result.
        if (vld_q[DIV_LAT-1:0] == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    busy_d     = (state_d != ST_IDLE);
  end

`ifdef SOFTMAX_DIV_ZERO_GUARD_EN
  assign div_c = ((sum_q & FP_EXP_MASK) == FP_ZERO) ? FP_ZERO : fp_div(rd_data, sum_q);
`else
  assign div_c = fp_div(rd_data, sum_q);
`endif

  // Read-stage + divider-latency pipe; valid/last ride alongside the data.
  always_comb begin
    vld_d    = {vld_q[DIV_LAT-1:0], rd_en_c};
    lst_d    = {lst_q[DIV_LAT-1:0], last_issue_c};
    dat_d[0] = div_c;
    for (int i = 1; i < DIV_LAT; i++) dat_d[i] = dat_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      vld_q      <= '0;
      lst_q      <= '0;
      for (int i = 0; i < DIV_LAT; i++) dat_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      dat_q      <= dat_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign ovf_err    = ovf_q;
  assign prob_valid = vld_q[DIV_LAT];
  assign prob_last  = lst_q[DIV_LAT];
  assign prob_out   = dat_q[DIV_LAT-1];

endmodule
